mem_arbiter: RTL
================

# mem_arbiter

Shares the core's single memory port between the instruction-fetch requester and the data (load/store) requester. It sits between the control/datapath and the memory, and serialises accesses with valid/ready request handshakes and a one-outstanding-transaction state machine. Responses are routed back to the requester that issued the transaction.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width; `DATA_W/8` byte-enable bits.

Ports:
- `clk_i`  in  1  clock. One clock; reset is asynchronous and active-high.
- `reset_i`  in  1  asynchronous, active-high reset.
- `if_req_valid_i`  in  1  fetch request valid.
- `if_req_ready_o`  out  1  fetch request accepted this cycle.
- `if_req_addr_i`  in  ADDR_W  fetch address.
- `if_rsp_valid_o`  out  1  fetch response, one-cycle pulse.
- `if_rsp_data_o`  out  DATA_W  fetched word.
- `d_req_valid_i`  in  1  data request valid.
- `d_req_ready_o`  out  1  data request accepted this cycle.
- `d_req_addr_i`  in  ADDR_W  data address.
- `d_req_we_i`  in  1  1 = store, 0 = load.
- `d_req_wdata_i`  in  DATA_W  store data.
- `d_req_wmask_i`  in  DATA_W/8  store byte enables.
- `d_rsp_valid_o`  out  1  data response, one-cycle pulse; loads and stores.
- `d_rsp_data_o`  out  DATA_W  load data; 0 for stores.
- `mem_req_valid_o`  out  1  memory request valid.
- `mem_req_ready_i`  in  1  memory accepts request.
- `mem_req_addr_o`  out  ADDR_W  memory address.
- `mem_req_we_o`  out  1  memory write enable.
- `mem_req_wdata_o`  out  DATA_W  memory write data.
- `mem_req_wmask_o`  out  DATA_W/8  memory byte enables.
- `mem_rsp_valid_i`  in  1  memory response valid; reads and writes.
- `mem_rsp_data_i`  in  DATA_W  memory read data.

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE: arbitrate among the valid requesters. The winner's `*_req_ready_o` = 1 combinationally, and only the winner's.
  - On the handshake, latch the addr/we/wdata/wmask fields and the owner, then go to ISSUE.
  - Fetch requests latch we = 0, wmask = 0, wdata = 0.
- ISSUE: `mem_req_valid_o` = 1 with the latched fields, held stable until `mem_req_ready_i` = 1, then go to WAIT.
- WAIT: on `mem_rsp_valid_i`, register `mem_rsp_data_i` (0 for stores) into the owner's `*_rsp_data_o` and pulse the owner's `*_rsp_valid_o` for exactly one cycle (the next cycle). Go to IDLE.
- `mem_rsp_valid_i` is ignored in IDLE and ISSUE.
- Requesters hold valid and payload stable until ready. Responses have no backpressure.
- Fixed priority: data wins over fetch when both are valid.
- Both `*_req_ready_o` = 0 outside IDLE.
- `*_rsp_data_o` holds its last value between pulses.

## Timing
- Reset values:
  - State: IDLE.
  - All `*_ready_o`, `*_rsp_valid_o`, `mem_req_valid_o`, `mem_req_we_o`: 0.
  - All data, address and mask outputs: 0.
  - Round-robin pointer: "fetch last", so data wins first.
- Latency:
  - Request handshake at cycle t → `mem_req_valid_o` at t+1.
  - With memory ready at t+1 and response at t+k (k ≥ 2) → `*_rsp_valid_o` at t+k+1.
- Back-to-back: a new request can be accepted in the same cycle `*_rsp_valid_o` is high. Minimum spacing between handshakes is 3 cycles.
- Simultaneous valid: exactly one grant per IDLE cycle. The loser keeps valid and is granted on a later IDLE.
- Reset mid-transaction (ISSUE or WAIT): return to IDLE immediately and drop the transaction. No response pulse is generated, and a late `mem_rsp_valid_i` is ignored.
- Valid dropped by a requester before the handshake is illegal; behaviour is undefined.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration. When both requesters are valid in IDLE, grant the requester not granted last. A 1-bit last-grant register updates on every handshake.
- `MEM_ARB_RR_EN` undefined: fixed priority, data always wins, no last-grant register. Fetch can starve under continuous data requests.

## Test plan
- Single fetch, addr 0x100; memory ready immediately, response 0xDEADBEEF 2 cycles later → `if_rsp_valid_o` one pulse at t+3 with data 0xDEADBEEF; `d_rsp_valid_o` stays 0.
- Store, addr 0x200, wdata 0x12345678, wmask 0b0011; `mem_req_ready_i` low 3 cycles → `mem_req_*` held stable for all 4 ISSUE cycles; `d_rsp_valid_o` pulses with data 0.
- Fetch and data valid together for 4 transactions:
  - Fixed priority: grant order D, D, D, D.
  - With `MEM_ARB_RR_EN`: grant order D, F, D, F.
- `reset_i` asserted while in WAIT, then `mem_rsp_valid_i` pulses → no `*_rsp_valid_o`; all outputs 0; next request proceeds normally.
- Spurious `mem_rsp_valid_i` while IDLE → no response pulse, state unchanged.
- Back-to-back loads: new `d_req_valid_i` held during the previous response → handshake in the `d_rsp_valid_o` cycle; 3-cycle handshake spacing.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one memory port between fetch and data requesters
// Optional MEM_ARB_RR_EN: round-robin arbitration instead of fixed data priority.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                if_req_valid_i,
    output logic                if_req_ready_o,
    input  logic [ADDR_W-1:0]   if_req_addr_i,
    output logic                if_rsp_valid_o,
    output logic [DATA_W-1:0]   if_rsp_data_o,
    input  logic                d_req_valid_i,
    output logic                d_req_ready_o,
    input  logic [ADDR_W-1:0]   d_req_addr_i,
    input  logic                d_req_we_i,
    input  logic [DATA_W-1:0]   d_req_wdata_i,
    input  logic [DATA_W/8-1:0] d_req_wmask_i,
    output logic                d_rsp_valid_o,
    output logic [DATA_W-1:0]   d_rsp_data_o,
    output logic                mem_req_valid_o,
    input  logic                mem_req_ready_i,
    output logic [ADDR_W-1:0]   mem_req_addr_o,
    output logic                mem_req_we_o,
    output logic [DATA_W-1:0]   mem_req_wdata_o,
    output logic [DATA_W/8-1:0] mem_req_wmask_o,
    input  logic                mem_rsp_valid_i,
    input  logic [DATA_W-1:0]   mem_rsp_data_i
);
    localparam int MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t              state_q, state_d;
    logic                owner_d_q, owner_d_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [MASK_W-1:0]   wmask_q, wmask_d;
    logic                if_rsp_valid_q, if_rsp_valid_d;
    logic                d_rsp_valid_q, d_rsp_valid_d;
    logic [DATA_W-1:0]   if_rsp_data_q, if_rsp_data_d;
    logic [DATA_W-1:0]   d_rsp_data_q, d_rsp_data_d;
    logic                grant_d, grant_if;
    logic                rsp_fire;

`ifdef MEM_ARB_RR_EN
    // 1 = fetch was granted last; reset value lets data win first
    logic last_fetch_q, last_fetch_d;

    always_comb begin
        grant_d  = d_req_valid_i && (!if_req_valid_i || last_fetch_q);
        grant_if = if_req_valid_i && (!d_req_valid_i || !last_fetch_q);
    end
`else
    always_comb begin
        grant_d  = d_req_valid_i;
        grant_if = if_req_valid_i && !d_req_valid_i;
    end
`endif

    assign rsp_fire = (state_q == WAIT) && mem_rsp_valid_i;

    always_comb begin
        state_d        = state_q;
        owner_d_d      = owner_d_q;
        addr_d         = addr_q;
        we_d           = we_q;
        wdata_d        = wdata_q;
        wmask_d        = wmask_q;
        if_rsp_valid_d = 1'b0;
        d_rsp_valid_d  = 1'b0;
        if_rsp_data_d  = if_rsp_data_q;
        d_rsp_data_d   = d_rsp_data_q;
        if_req_ready_o = 1'b0;
        d_req_ready_o  = 1'b0;
`ifdef MEM_ARB_RR_EN
        last_fetch_d   = last_fetch_q;
`endif
        case (state_q)
            IDLE: begin
                d_req_ready_o  = grant_d;
                if_req_ready_o = grant_if;
                if (grant_d) begin
                    state_d   = ISSUE;
                    owner_d_d = 1'b1;
                    addr_d    = d_req_addr_i;
                    we_d      = d_req_we_i;
                    wdata_d   = d_req_wdata_i;
                    wmask_d   = d_req_wmask_i;
`ifdef MEM_ARB_RR_EN
                    last_fetch_d = 1'b0;
`endif
                end else if (grant_if) begin
                    state_d   = ISSUE;
                    owner_d_d = 1'b0;
                    addr_d    = if_req_addr_i;
                    we_d      = 1'b0;
                    wdata_d   = '0;
                    wmask_d   = '0;
`ifdef MEM_ARB_RR_EN
                    last_fetch_d = 1'b1;
`endif
                end
            end
            ISSUE: begin
                if (mem_req_ready_i) state_d = WAIT;
            end
            WAIT: begin
                if (rsp_fire) begin
                    state_d = IDLE;
                    if (owner_d_q) begin
                        d_rsp_valid_d = 1'b1;
                        d_rsp_data_d  = we_q ? '0 : mem_rsp_data_i;
                    end else begin
                        if_rsp_valid_d = 1'b1;
                        if_rsp_data_d  = mem_rsp_data_i;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q        <= IDLE;
            owner_d_q      <= 1'b0;
            addr_q         <= '0;
            we_q           <= 1'b0;
            wdata_q        <= '0;
            wmask_q        <= '0;
            if_rsp_valid_q <= 1'b0;
            d_rsp_valid_q  <= 1'b0;
            if_rsp_data_q  <= '0;
            d_rsp_data_q   <= '0;
`ifdef MEM_ARB_RR_EN
            last_fetch_q   <= 1'b1;
`endif
        end else begin
            state_q        <= state_d;
            owner_d_q      <= owner_d_d;
            addr_q         <= addr_d;
            we_q           <= we_d;
            wdata_q        <= wdata_d;
            wmask_q        <= wmask_d;
            if_rsp_valid_q <= if_rsp_valid_d;
            d_rsp_valid_q  <= d_rsp_valid_d;
            if_rsp_data_q  <= if_rsp_data_d;
            d_rsp_data_q   <= d_rsp_data_d;
`ifdef MEM_ARB_RR_EN
            last_fetch_q   <= last_fetch_d;
`endif
        end
    end

    assign mem_req_valid_o = (state_q == ISSUE);
    assign mem_req_addr_o  = addr_q;
    assign mem_req_we_o    = we_q;
    assign mem_req_wdata_o = wdata_q;
    assign mem_req_wmask_o = wmask_q;
    assign if_rsp_valid_o  = if_rsp_valid_q;
    assign if_rsp_data_o   = if_rsp_data_q;
    assign d_rsp_valid_o   = d_rsp_valid_q;
    assign d_rsp_data_o    = d_rsp_data_q;

endmodule
